// File: rtl/capi_intr_arb.sv
// capi_intr_arb: round-robin arbiter that shares one CAPI interrupt-request
// engine among nsrc sources. Each source event is latched as a sticky pending
// bit with its context/irq/aux. One request at a time goes out through a
// registered valid/ready stage. In-flight requests are limited to the engine
// tag pool and are retired by the engine's response pulse.
module capi_intr_arb #(
  parameter int nsrc         = 4,
  parameter int ctxtid_width = 16,
  parameter int irqsrc_width = 11,
  parameter int aux_width    = 1,
  parameter int max_outst    = 4,
  parameter int cnt_width    = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [nsrc-1:0]                i_src_v,
  input  logic [nsrc*ctxtid_width-1:0]   i_src_ctxt,
  input  logic [nsrc*irqsrc_width-1:0]   i_src_irq,
  input  logic [nsrc*aux_width-1:0]      i_src_aux,
  output logic                           o_req_v,
  input  logic                           o_req_r,
  output logic [ctxtid_width-1:0]        o_req_d_ctxt,
  output logic [irqsrc_width-1:0]        o_req_d_src,
  output logic [aux_width-1:0]           o_req_d_aux,
  input  logic                           i_rsp_v,
  output logic [nsrc-1:0]                o_pend,
  output logic [cnt_width-1:0]           o_outst,
  output logic [nsrc-1:0]                o_coal_v,
  output logic                           o_err
);

  localparam int idx_w = (nsrc > 1) ? $clog2(nsrc) : 1;
  typedef logic [idx_w-1:0] idx_t;

  logic [nsrc-1:0]         pend;
  logic [ctxtid_width-1:0] cap_ctxt [nsrc];
  logic [irqsrc_width-1:0] cap_irq  [nsrc];
  logic [aux_width-1:0]    cap_aux  [nsrc];
  logic [nsrc-1:0]         coal_q;
  logic                    err_q;

  idx_t                    rr;
  idx_t                    win;
  idx_t                    rr_next;
  logic                    found;
  logic                    grant;
  logic [nsrc-1:0]         gnt_vec;

  logic [cnt_width-1:0]    outst;
  logic [cnt_width-1:0]    outst_base;
  logic                    accept;
  logic                    rsp_dec;

  // The output stage can take a new request when empty or being drained now.
  assign accept  = !o_req_v || o_req_r;
  // A response frees its credit in the same cycle; an unmatched one frees nothing.
  assign rsp_dec = i_rsp_v && (outst != '0);
  assign outst_base = rsp_dec ? (outst - cnt_width'(1)) : outst;

  assign grant   = accept && found && (outst_base < cnt_width'(max_outst));
  assign rr_next = (win == idx_t'(nsrc - 1)) ? '0 : (win + idx_t'(1));

  // Winner search: first set pending bit at or after rr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < nsrc; k++) begin
      int j;
      j = (int'(rr) + k) % nsrc;
      if (!found && pend[j]) begin
        found = 1'b1;
        win   = idx_t'(j);
      end
    end
  end

  // One-hot view of this cycle's grant for the per-source pending logic.
  always_comb begin
    gnt_vec = '0;
    if (grant) gnt_vec[win] = 1'b1;
  end

  // Pending bits, captured payloads and coalesce pulses. A grant consumes the
  // old capture, so an event in the grant cycle re-arms with fresh data.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend   <= '0;
      coal_q <= '0;
      for (int i = 0; i < nsrc; i++) begin
        cap_ctxt[i] <= '0;
        cap_irq[i]  <= '0;
        cap_aux[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < nsrc; i++) begin
        coal_q[i] <= i_src_v[i] && pend[i] && !gnt_vec[i];
        if (i_src_v[i] && !(pend[i] && !gnt_vec[i])) begin
          pend[i]     <= 1'b1;
          cap_ctxt[i] <= i_src_ctxt[i*ctxtid_width +: ctxtid_width];
          cap_irq[i]  <= i_src_irq[i*irqsrc_width +: irqsrc_width];
          cap_aux[i]  <= i_src_aux[i*aux_width +: aux_width];
        end else if (gnt_vec[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Registered request stage: load on grant, hold until accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_req_v      <= 1'b0;
      o_req_d_ctxt <= '0;
      o_req_d_src  <= '0;
      o_req_d_aux  <= '0;
    end else if (grant) begin
      o_req_v      <= 1'b1;
      o_req_d_ctxt <= cap_ctxt[win];
      o_req_d_src  <= cap_irq[win];
      o_req_d_aux  <= cap_aux[win];
    end else if (o_req_r) begin
      o_req_v <= 1'b0;
    end
  end

  // In-flight counter, underflow flag and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst <= '0;
      err_q <= 1'b0;
      rr    <= '0;
    end else begin
      outst <= outst_base + cnt_width'(grant);
      err_q <= i_rsp_v && (outst == '0) && !grant;
      if (grant) rr <= rr_next;
    end
  end

  assign o_pend   = pend;
  assign o_outst  = outst;
  assign o_coal_v = coal_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_capi_intr_arb.sv
// Scoreboard bench for capi_intr_arb: a cycle reference model pushes the
// expected request on every grant; a monitor pops on each accepted request.
module tb_capi_intr_arb;

  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int IW  = 11;
  localparam int AW  = 1;
  localparam int MAX = 4;
  localparam int OW  = 3;

  typedef struct packed {
    logic [CW-1:0] ctxt;
    logic [IW-1:0] irq;
    logic [AW-1:0] aux;
  } req_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    i_src_v;
  logic [N*CW-1:0] i_src_ctxt;
  logic [N*IW-1:0] i_src_irq;
  logic [N*AW-1:0] i_src_aux;
  logic            o_req_v;
  logic            o_req_r;
  logic [CW-1:0]   o_req_d_ctxt;
  logic [IW-1:0]   o_req_d_src;
  logic [AW-1:0]   o_req_d_aux;
  logic            i_rsp_v;
  logic [N-1:0]    o_pend;
  logic [OW-1:0]   o_outst;
  logic [N-1:0]    o_coal_v;
  logic            o_err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit   [N-1:0] m_pend;
  req_t         m_cap [N];
  int           m_rr;
  int           m_outst;
  bit           m_req_v;
  bit   [N-1:0] m_coal;
  bit           m_err;
  req_t         exp_q[$];

  capi_intr_arb #(
    .nsrc(N), .ctxtid_width(CW), .irqsrc_width(IW), .aux_width(AW),
    .max_outst(MAX), .cnt_width(OW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_src_v(i_src_v), .i_src_ctxt(i_src_ctxt), .i_src_irq(i_src_irq), .i_src_aux(i_src_aux),
    .o_req_v(o_req_v), .o_req_r(o_req_r),
    .o_req_d_ctxt(o_req_d_ctxt), .o_req_d_src(o_req_d_src), .o_req_d_aux(o_req_d_aux),
    .i_rsp_v(i_rsp_v), .o_pend(o_pend), .o_outst(o_outst), .o_coal_v(o_coal_v), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: applies the arbitration rules once per clock edge.
  always @(posedge clk) begin
    int g;
    int base;
    bit [N-1:0] oldp;
    if (reset) begin
      m_pend  = '0;
      m_rr    = 0;
      m_outst = 0;
      m_req_v = 1'b0;
      m_coal  = '0;
      m_err   = 1'b0;
      for (int i = 0; i < N; i++) m_cap[i] = '0;
      exp_q.delete();
    end else begin
      oldp = m_pend;
      base = (i_rsp_v && m_outst > 0) ? m_outst - 1 : m_outst;
      g = -1;
      if ((!m_req_v || o_req_r) && base < MAX) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_rr + k) % N;
          if (g < 0 && oldp[j]) g = j;
        end
      end
      m_err = i_rsp_v && (m_outst == 0) && (g < 0);
      for (int i = 0; i < N; i++) m_coal[i] = i_src_v[i] && oldp[i] && (i != g);
      if (g >= 0) begin
        exp_q.push_back(m_cap[g]);
        m_req_v   = 1'b1;
        m_pend[g] = 1'b0;
        m_rr      = (g + 1) % N;
        m_outst   = base + 1;
      end else begin
        if (o_req_r) m_req_v = 1'b0;
        m_outst = base;
      end
      for (int i = 0; i < N; i++) begin
        if (i_src_v[i] && !m_coal[i]) begin
          m_pend[i] = 1'b1;
          m_cap[i]  = '{ctxt: i_src_ctxt[i*CW +: CW], irq: i_src_irq[i*IW +: IW], aux: i_src_aux[i*AW +: AW]};
        end
      end
    end
  end

  // Per-cycle status compare against the model.
  always @(negedge clk) begin
    check("pend",  32'(o_pend),   32'(m_pend));
    check("outst", 32'(o_outst),  32'(m_outst));
    check("req_v", 32'(o_req_v),  32'(m_req_v));
    check("coal",  32'(o_coal_v), 32'(m_coal));
    check("err",   32'(o_err),    32'(m_err));
  end

  // Monitor: presented request must match the scoreboard head; pop on accept.
  always @(negedge clk) begin
    if (o_req_v && !reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_unexpected: got %h expected none", {o_req_d_ctxt, o_req_d_src, o_req_d_aux});
      end else begin
        check("req_data", 32'({o_req_d_ctxt, o_req_d_src, o_req_d_aux}), 32'(exp_q[0]));
        if (o_req_r) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    i_src_v = '0;
    i_rsp_v = 1'b0;
  endtask

  task automatic fire(input int s, input logic [CW-1:0] c, input logic [IW-1:0] q, input logic [AW-1:0] a);
    i_src_v[s]            = 1'b1;
    i_src_ctxt[s*CW +: CW] = c;
    i_src_irq[s*IW +: IW]  = q;
    i_src_aux[s*AW +: AW]  = a;
  endtask

  task automatic rsp_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      i_rsp_v = 1'b1;
      step();
    end
  endtask

  initial begin
    reset      = 1'b1;
    i_src_v    = '0;
    i_src_ctxt = '0;
    i_src_irq  = '0;
    i_src_aux  = '0;
    o_req_r    = 1'b0;
    i_rsp_v    = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_req_v", 32'(o_req_v), 32'd0);
    check("rst_ctxt",  32'(o_req_d_ctxt), 32'd0);
    check("rst_src",   32'(o_req_d_src), 32'd0);
    check("rst_aux",   32'(o_req_d_aux), 32'd0);

    // single event on source 2
    o_req_r = 1'b1;
    fire(2, 16'h0123, 11'h05A, 1'b1);
    step();
    check("single_pend", 32'(o_pend), 32'h4);
    step();
    check("single_v",    32'(o_req_v), 32'd1);
    check("single_ctxt", 32'(o_req_d_ctxt), 32'h0123);
    check("single_irq",  32'(o_req_d_src), 32'h05A);
    check("single_aux",  32'(o_req_d_aux), 32'd1);
    check("single_outst", 32'(o_outst), 32'd1);
    step();
    check("single_drop", 32'(o_req_v), 32'd0);
    rsp_cycles(1);
    check("single_ret", 32'(o_outst), 32'd0);

    // round robin with immediate responses
    for (int s = 0; s < N; s++) fire(s, 16'(16'h1000 + s), 11'(s + 1), 1'(s));
    rsp_cycles(7);
    // backpressure: hold for several cycles
    for (int s = 0; s < N; s++) fire(s, 16'(16'h2000 + s), 11'(s + 8), 1'(s + 1));
    o_req_r = 1'b0;
    repeat (6) step();
    o_req_r = 1'b1;
    rsp_cycles(10);

    // credit limit
    for (int c = 0; c < 10; c++) begin
      for (int s = 0; s < N; s++) fire(s, 16'(16'h3000 + c * 4 + s), 11'(c * 4 + s), 1'(c));
      step();
    end
    check("credit_full", 32'(o_outst), 32'd4);
    check("credit_idle", 32'(o_req_v), 32'd0);
    rsp_cycles(1);
    check("credit_one_outst", 32'(o_outst), 32'd4);
    check("credit_one_v",     32'(o_req_v), 32'd1);
    rsp_cycles(10);

    // coalescing while output is busy
    o_req_r = 1'b0;
    fire(0, 16'h4000, 11'h0AA, 1'b0);
    step();
    step();
    fire(1, 16'h4111, 11'h111, 1'b1);
    step();
    fire(1, 16'h4222, 11'h222, 1'b0);
    step();
    check("coal_pulse", 32'(o_coal_v), 32'h2);
    step();
    o_req_r = 1'b1;
    step();
    check("coal_first_irq", 32'(o_req_d_src), 32'h111);
    // event landing in the grant cycle
    o_req_r = 1'b0;
    fire(1, 16'h4333, 11'h333, 1'b0);
    step();
    o_req_r = 1'b1;
    fire(1, 16'h4444, 11'h444, 1'b1);
    step();
    check("gcyc_coal", 32'(o_coal_v), 32'd0);
    check("gcyc_irq_old", 32'(o_req_d_src), 32'h333);
    step();
    check("gcyc_irq_new", 32'(o_req_d_src), 32'h444);
    rsp_cycles(6);

    // underflow
    check("uf_pre", 32'(o_outst), 32'd0);
    rsp_cycles(1);
    check("uf_err",   32'(o_err), 32'd1);
    check("uf_outst", 32'(o_outst), 32'd0);
    step();
    check("uf_err_clr", 32'(o_err), 32'd0);
    fire(3, 16'h5333, 11'h533, 1'b1);
    step();
    rsp_cycles(1);
    check("uf_gnt_outst", 32'(o_outst), 32'd1);
    check("uf_gnt_err",   32'(o_err), 32'd0);
    rsp_cycles(2);

    // reset mid-operation
    fire(0, 16'h6000, 11'h600, 1'b0);
    fire(1, 16'h6001, 11'h601, 1'b1);
    step();
    step();
    step();
    o_req_r = 1'b0;
    fire(0, 16'h6100, 11'h610, 1'b0);
    fire(2, 16'h6102, 11'h612, 1'b0);
    fire(3, 16'h6103, 11'h613, 1'b1);
    step();
    check("pre_rst_outst", 32'(o_outst), 32'd2);
    check("pre_rst_pend",  32'(o_pend), 32'hD);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_v",     32'(o_req_v), 32'd0);
    check("mid_rst_pend",  32'(o_pend), 32'd0);
    check("mid_rst_outst", 32'(o_outst), 32'd0);
    check("mid_rst_data",  32'({o_req_d_ctxt, o_req_d_src, o_req_d_aux}), 32'd0);
    o_req_r = 1'b1;
    fire(3, 16'h7003, 11'h703, 1'b1);
    step();
    step();
    check("post_rst_v",   32'(o_req_v), 32'd1);
    check("post_rst_irq", 32'(o_req_d_src), 32'h703);
    rsp_cycles(2);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++) i_src_v[s] = ($urandom_range(0, 3) == 0);
      i_src_ctxt = {$urandom(), $urandom()};
      i_src_irq  = 44'({$urandom(), $urandom()});
      i_src_aux  = 4'($urandom());
      o_req_r    = ($urandom_range(0, 9) < 7);
      i_rsp_v    = ($urandom_range(0, 2) == 0);
      step();
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
